raster_scan_ctrl: RTL and testbench

Per-triangle scan sequencer for the 3-edge-function rasterizer. Accepts one triangle and computes its screen-clamped bounding box. Issues every pixel of the box to the rasterizer through its valid/ready input, consumes the rasterizer results, and forwards only inside pixels as fragments. Signals completion once all issued pixels have returned. Sits between the triangle setup stage and the fragment/pixel-write stage.

---
 rtl/raster_scan_ctrl_if.sv | 39 +++
 rtl/raster_scan_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_raster_scan_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_scan_ctrl_if.sv
// Bus bundle for raster_scan_ctrl: triangle input, rasterizer issue/return and fragment output.
// The master modport is the scan controller; the slave modport is its surroundings.
interface raster_scan_ctrl_if;
    logic        tri_valid;
    logic        tri_ready;
    logic [32:0] tri_x;
    logic [32:0] tri_y;
    logic [32:0] ras_vx;
    logic [32:0] ras_vy;
    logic [10:0] ras_pixel_x;
    logic [10:0] ras_pixel_y;
    logic        ras_valid;
    logic        ras_ready;
    logic        ras_out_valid;
    logic        ras_out_ready;
    logic        ras_inside;
    logic [10:0] ras_out_x;
    logic [10:0] ras_out_y;
    logic        frag_valid;
    logic        frag_ready;
    logic [10:0] frag_x;
    logic [10:0] frag_y;
    logic        done;
    logic [19:0] stat_frag_count;

    modport master (
        input  tri_valid, tri_x, tri_y, ras_ready, ras_out_valid, ras_inside,
               ras_out_x, ras_out_y, frag_ready,
        output tri_ready, ras_vx, ras_vy, ras_pixel_x, ras_pixel_y, ras_valid,
               ras_out_ready, frag_valid, frag_x, frag_y, done, stat_frag_count
    );

    modport slave (
        output tri_valid, tri_x, tri_y, ras_ready, ras_out_valid, ras_inside,
               ras_out_x, ras_out_y, frag_ready,
        input  tri_ready, ras_vx, ras_vy, ras_pixel_x, ras_pixel_y, ras_valid,
               ras_out_ready, frag_valid, frag_x, frag_y, done, stat_frag_count
    );
endinterface

// File: rtl/raster_scan_ctrl.sv
// Per-triangle scan sequencer: clamped bounding box, throttled pixel issue, inside-fragment forwarding.
// Define RASTER_STATS_EN to build the per-triangle fragment counter driving stat_frag_count.
module raster_scan_ctrl #(
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned MAX_INFLIGHT = 15
) (
    input  logic               clk,
    input  logic               reset,
    raster_scan_ctrl_if.master bus
);
    localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned PW = 11;
    localparam int unsigned SW = 20;
    localparam logic signed [PW-1:0] X_LAST   = PW'(SCREEN_W - 1);
    localparam logic signed [PW-1:0] Y_LAST   = PW'(SCREEN_H - 1);
    localparam logic        [CW-1:0] INFL_MAX = CW'(MAX_INFLIGHT);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t           r_state;
    logic             r_tri_ready;
    logic             r_ras_valid;
    logic             r_done;
    logic [3*PW-1:0]  r_vx;
    logic [3*PW-1:0]  r_vy;
    logic [PW-1:0]    r_px;
    logic [PW-1:0]    r_py;
    logic [PW-1:0]    r_min_x;
    logic [PW-1:0]    r_max_x;
    logic [PW-1:0]    r_max_y;
    logic [CW-1:0]    r_inflight;

    logic signed [PW-1:0] w_min_x, w_max_x, w_min_y, w_max_y;
    logic                 w_empty, w_accept, w_in_hs, w_out_hs, w_out_ready;
    logic                 w_frag_valid, w_last, w_enter_done;
    logic [CW-1:0]        w_inflight_nx;

    function automatic logic signed [PW-1:0] min3(input logic [3*PW-1:0] v);
        logic signed [PW-1:0] a, b, c, m;
        a = $signed(v[PW-1:0]);
        b = $signed(v[2*PW-1:PW]);
        c = $signed(v[3*PW-1:2*PW]);
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [PW-1:0] max3(input logic [3*PW-1:0] v);
        logic signed [PW-1:0] a, b, c, m;
        a = $signed(v[PW-1:0]);
        b = $signed(v[2*PW-1:PW]);
        c = $signed(v[3*PW-1:2*PW]);
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Raw (unclamped) box; emptiness is judged before clamping to the screen
    always_comb begin
        w_min_x = min3(r_vx);
        w_max_x = max3(r_vx);
        w_min_y = min3(r_vy);
        w_max_y = max3(r_vy);
        w_empty = w_max_x[PW-1] || (w_min_x > X_LAST) || w_max_y[PW-1] || (w_min_y > Y_LAST);
    end

    assign w_accept     = (r_state == S_IDLE) && r_tri_ready && bus.tri_valid;
    assign w_in_hs      = r_ras_valid && bus.ras_ready;
    assign w_out_ready  = bus.frag_ready || !bus.ras_inside;
    assign w_frag_valid = bus.ras_out_valid && bus.ras_inside;
    // Results with nothing outstanding (e.g. left over from an aborted triangle) never underflow the count
    assign w_out_hs     = bus.ras_out_valid && w_out_ready && (r_inflight != '0);
    assign w_last       = (r_px == r_max_x) && (r_py == r_max_y);
    assign w_enter_done = ((r_state == S_SETUP) && w_empty) || ((r_state == S_DRAIN) && (r_inflight == '0));

    always_comb begin
        w_inflight_nx = r_inflight;
        if (w_in_hs && !w_out_hs) begin
            w_inflight_nx = r_inflight + CW'(1);
        end else if (!w_in_hs && w_out_hs) begin
            w_inflight_nx = r_inflight - CW'(1);
        end
    end

    // Scan FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_tri_ready <= 1'b0;
            r_ras_valid <= 1'b0;
            r_done      <= 1'b0;
            r_vx        <= '0;
            r_vy        <= '0;
            r_px        <= '0;
            r_py        <= '0;
            r_min_x     <= '0;
            r_max_x     <= '0;
            r_max_y     <= '0;
            r_inflight  <= '0;
        end else begin
            r_done      <= 1'b0;
            r_ras_valid <= 1'b0;
            r_inflight  <= w_inflight_nx;
            unique case (r_state)
                S_IDLE: begin
                    r_tri_ready <= 1'b1;
                    if (w_accept) begin
                        r_tri_ready <= 1'b0;
                        r_vx        <= bus.tri_x;
                        r_vy        <= bus.tri_y;
                        r_state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_min_x     <= w_min_x[PW-1] ? '0 : $unsigned(w_min_x);
                        r_px        <= w_min_x[PW-1] ? '0 : $unsigned(w_min_x);
                        r_py        <= w_min_y[PW-1] ? '0 : $unsigned(w_min_y);
                        r_max_x     <= (w_max_x > X_LAST) ? $unsigned(X_LAST) : $unsigned(w_max_x);
                        r_max_y     <= (w_max_y > Y_LAST) ? $unsigned(Y_LAST) : $unsigned(w_max_y);
                        r_ras_valid <= (w_inflight_nx < INFL_MAX);
                        r_state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_ras_valid <= (w_inflight_nx < INFL_MAX);
                    if (w_in_hs) begin
                        if (w_last) begin
                            r_ras_valid <= 1'b0;
                            r_state     <= S_DRAIN;
                        end else if (r_px < r_max_x) begin
                            r_px <= r_px + PW'(1);
                        end else begin
                            r_px <= r_min_x;
                            r_py <= r_py + PW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_inflight == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_tri_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.tri_ready     = r_tri_ready;
    assign bus.ras_vx        = r_vx;
    assign bus.ras_vy        = r_vy;
    assign bus.ras_pixel_x   = r_px;
    assign bus.ras_pixel_y   = r_py;
    assign bus.ras_valid     = r_ras_valid;
    assign bus.done          = r_done;
    assign bus.ras_out_ready = w_out_ready;
    assign bus.frag_valid    = w_frag_valid;
    assign bus.frag_x        = bus.ras_out_x;
    assign bus.frag_y        = bus.ras_out_y;

`ifdef RASTER_STATS_EN
    logic [SW-1:0] r_frag_cnt;
    logic [SW-1:0] r_stat;
    logic [SW-1:0] w_frag_cnt_nx;

    always_comb begin
        w_frag_cnt_nx = r_frag_cnt;
        if (w_frag_valid && bus.frag_ready) begin
            w_frag_cnt_nx = r_frag_cnt + SW'(1);
        end
    end

    // Running count is published on the cycle the done pulse is raised
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frag_cnt <= '0;
            r_stat     <= '0;
        end else begin
            r_frag_cnt <= w_accept ? '0 : w_frag_cnt_nx;
            if (w_enter_done) begin
                r_stat <= w_frag_cnt_nx;
            end
        end
    end

    assign bus.stat_frag_count = r_stat;
`else
    assign bus.stat_frag_count = '0;
`endif
endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Directed self-checking bench for raster_scan_ctrl with a queue-based rasterizer model.
module tb_raster_scan_ctrl;
`ifdef RASTER_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    raster_scan_ctrl_if bus ();

    raster_scan_ctrl #(.SCREEN_W(640), .SCREEN_H(480), .MAX_INFLIGHT(15)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        int unsigned t;
    } ent_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int          inside_mode = 1;
    bit          ready_toggle = 1'b0;
    bit          frag_rdy = 1'b1;
    ent_t        pq[$];
    logic [10:0] iss_x[$];
    logic [10:0] iss_y[$];
    int          frag_cnt, drop_stall, done_cnt, early_done, over_cnt, comb_bad, vx_bad, max_pend;
    logic [19:0] last_stat;
    logic [32:0] exp_vx, exp_vy;

    function automatic logic [32:0] pack3(input int a, input int b, input int c);
        return {11'(c), 11'(b), 11'(a)};
    endfunction

    function automatic bit is_inside(input logic [10:0] x, input logic [10:0] y);
        case (inside_mode)
            0:       return (int'(x) + int'(y)) <= 23;
            2:       return (x[0] ^ y[0]);
            default: return 1'b1;
        endcase
    endfunction

    function automatic int order_errs(input int x0, input int x1, input int y0, input int y1);
        int bad = 0;
        int k = 0;
        for (int yy = y0; yy <= y1; yy++) begin
            for (int xx = x0; xx <= x1; xx++) begin
                if (k >= iss_x.size() || iss_x[k] !== 11'(xx) || iss_y[k] !== 11'(yy)) bad++;
                k++;
            end
        end
        return bad;
    endfunction

    // Rasterizer model: drives at negedge, records handshakes 1 time unit later
    always @(negedge clk) begin
        bit in_hs, out_hs, fr;
        fr = frag_rdy;
        bus.ras_ready  = ready_toggle ? cyc[0] : 1'b1;
        bus.frag_ready = fr;
        if (pq.size() > 0 && (cyc - pq[0].t) >= 2) begin
            bus.ras_out_valid = 1'b1;
            bus.ras_out_x     = pq[0].x;
            bus.ras_out_y     = pq[0].y;
            bus.ras_inside    = is_inside(pq[0].x, pq[0].y);
        end else begin
            bus.ras_out_valid = 1'b0;
            bus.ras_out_x     = '0;
            bus.ras_out_y     = '0;
            bus.ras_inside    = 1'b0;
        end
        #1;
        if (!rst_n) begin
            pq.delete();
        end else begin
            if (bus.frag_valid !== (bus.ras_out_valid && bus.ras_inside) ||
                (bus.frag_valid && (bus.frag_x !== bus.ras_out_x || bus.frag_y !== bus.ras_out_y)) ||
                bus.ras_out_ready !== (fr || !bus.ras_inside)) comb_bad++;
            if (bus.ras_valid && pq.size() >= 15) over_cnt++;
            in_hs  = bus.ras_valid && bus.ras_ready;
            out_hs = bus.ras_out_valid && bus.ras_out_ready;
            if (bus.frag_valid && bus.frag_ready) frag_cnt++;
            if (out_hs && !bus.ras_inside && !fr) drop_stall++;
            if (out_hs) void'(pq.pop_front());
            if (in_hs) begin
                iss_x.push_back(bus.ras_pixel_x);
                iss_y.push_back(bus.ras_pixel_y);
                pq.push_back('{bus.ras_pixel_x, bus.ras_pixel_y, cyc});
                if (bus.ras_vx !== exp_vx || bus.ras_vy !== exp_vy) vx_bad++;
            end
            if (pq.size() > max_pend) max_pend = pq.size();
            if (bus.done) begin
                done_cnt++;
                last_stat = bus.stat_frag_count;
                if (pq.size() != 0) early_done++;
            end
        end
        cyc++;
    end

    task automatic clear_stats();
        frag_cnt = 0; drop_stall = 0; early_done = 0; over_cnt = 0;
        comb_bad = 0; vx_bad = 0; max_pend = 0; done_cnt = 0;
        iss_x.delete(); iss_y.delete();
    endtask

    // Offers a triangle once tri_ready is seen; returns at the negedge after the accept edge
    task automatic start_tri(input logic [32:0] vx, input logic [32:0] vy, output bit ok);
        ok = 1'b0;
        exp_vx = vx;
        exp_vy = vy;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.tri_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) return;
        bus.tri_x = vx;
        bus.tri_y = vy;
        bus.tri_valid = 1'b1;
        @(negedge clk);
        bus.tri_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        int d0 = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #2;
            if (done_cnt != d0) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.ras_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ras_valid got %b want 0", bus.ras_valid); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_cmp++; if ({bus.ras_vx, bus.ras_vy} !== 66'd0) begin n_fail++; $display("FAIL reset_vxvy got %h/%h want 0", bus.ras_vx, bus.ras_vy); end
        n_cmp++; if ({bus.ras_pixel_x, bus.ras_pixel_y} !== 22'd0) begin n_fail++; $display("FAIL reset_pixel got %0d,%0d want 0,0", bus.ras_pixel_x, bus.ras_pixel_y); end
        n_cmp++; if (bus.stat_frag_count !== 20'd0) begin n_fail++; $display("FAIL reset_stat got %0d want 0", bus.stat_frag_count); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.tri_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tri_ready got %b want 1", bus.tri_ready); end
    endtask

    task automatic test_small_tri();
        bit ok, seen;
        clear_stats(); inside_mode = 0; ready_toggle = 1'b0; frag_rdy = 1'b1;
        start_tri(pack3(10, 13, 10), pack3(10, 10, 13), ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL small_accept got %b want 1", ok); end
        n_cmp++; if (bus.ras_valid !== 1'b0) begin n_fail++; $display("FAIL small_valid_t1 got %b want 0", bus.ras_valid); end
        @(negedge clk);
        n_cmp++; if (bus.ras_valid !== 1'b1) begin n_fail++; $display("FAIL small_valid_t2 got %b want 1", bus.ras_valid); end
        n_cmp++; if ({bus.ras_pixel_x, bus.ras_pixel_y} !== {11'd10, 11'd10}) begin n_fail++; $display("FAIL small_first_pixel got %0d,%0d want 10,10", bus.ras_pixel_x, bus.ras_pixel_y); end
        wait_done(200, seen);
        n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL small_done_seen got %b want 1", seen); end
        n_cmp++; if (iss_x.size() !== 16) begin n_fail++; $display("FAIL small_issued got %0d want 16", iss_x.size()); end
        n_cmp++; if (order_errs(10, 13, 10, 13) !== 0) begin n_fail++; $display("FAIL small_order got %0d bad want 0", order_errs(10, 13, 10, 13)); end
        n_cmp++; if (frag_cnt !== 10) begin n_fail++; $display("FAIL small_frags got %0d want 10", frag_cnt); end
        n_cmp++; if (early_done !== 0) begin n_fail++; $display("FAIL small_done_before_results got %0d want 0", early_done); end
        n_cmp++; if (vx_bad !== 0) begin n_fail++; $display("FAIL small_vx_stable got %0d bad want 0", vx_bad); end
        n_cmp++; if (last_stat !== (STATS_ON ? 20'd10 : 20'd0)) begin n_fail++; $display("FAIL small_stat got %0d want %0d", last_stat, STATS_ON ? 10 : 0); end
        repeat (4) @(negedge clk);
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL small_done_pulses got %0d want 1", done_cnt); end
    endtask

    task automatic test_offscreen();
        bit ok;
        clear_stats(); inside_mode = 1;
        start_tri(pack3(-50, -40, -50), pack3(-50, -50, -40), ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL off_accept got %b want 1", ok); end
        @(negedge clk);
        n_cmp++; if ({bus.done, bus.ras_valid} !== 2'b10) begin n_fail++; $display("FAIL off_done_t2 got done=%b valid=%b want 1,0", bus.done, bus.ras_valid); end
        @(negedge clk);
        n_cmp++; if ({bus.tri_ready, bus.done} !== 2'b10) begin n_fail++; $display("FAIL off_ready_t3 got ready=%b done=%b want 1,0", bus.tri_ready, bus.done); end
        repeat (3) @(negedge clk);
        n_cmp++; if (iss_x.size() !== 0 || done_cnt !== 1) begin n_fail++; $display("FAIL off_no_issue got issued=%0d done=%0d want 0,1", iss_x.size(), done_cnt); end
    endtask

    task automatic test_screen_edge();
        bit ok, seen;
        clear_stats(); inside_mode = 1;
        start_tri(pack3(630, 700, 630), pack3(470, 470, 520), ok);
        wait_done(400, seen);
        n_cmp++; if ({ok, seen} !== 2'b11) begin n_fail++; $display("FAIL edge_done got ok=%b seen=%b want 1,1", ok, seen); end
        n_cmp++; if (iss_x.size() !== 100) begin n_fail++; $display("FAIL edge_issued got %0d want 100", iss_x.size()); end
        n_cmp++; if (order_errs(630, 639, 470, 479) !== 0) begin n_fail++; $display("FAIL edge_order got %0d bad want 0", order_errs(630, 639, 470, 479)); end
        n_cmp++; if (frag_cnt !== 100) begin n_fail++; $display("FAIL edge_frags got %0d want 100", frag_cnt); end
    endtask

    task automatic test_backpressure();
        bit ok, seen;
        clear_stats(); inside_mode = 2; ready_toggle = 1'b1; frag_rdy = 1'b0;
        start_tri(pack3(0, 7, 0), pack3(0, 0, 7), ok);
        repeat (50) @(negedge clk);
        n_cmp++; if (max_pend !== 15) begin n_fail++; $display("FAIL bp_saturate got %0d want 15", max_pend); end
        n_cmp++; if (over_cnt !== 0) begin n_fail++; $display("FAIL bp_valid_when_full got %0d want 0", over_cnt); end
        n_cmp++; if (drop_stall < 1) begin n_fail++; $display("FAIL bp_outside_drained got %0d want >=1", drop_stall); end
        n_cmp++; if (frag_cnt !== 0) begin n_fail++; $display("FAIL bp_no_frag_stalled got %0d want 0", frag_cnt); end
        frag_rdy = 1'b1;
        wait_done(600, seen);
        ready_toggle = 1'b0;
        n_cmp++; if ({ok, seen} !== 2'b11) begin n_fail++; $display("FAIL bp_done got ok=%b seen=%b want 1,1", ok, seen); end
        n_cmp++; if (iss_x.size() !== 64 || order_errs(0, 7, 0, 7) !== 0) begin n_fail++; $display("FAIL bp_issue got %0d issued want 64 in order", iss_x.size()); end
        n_cmp++; if (frag_cnt !== 32) begin n_fail++; $display("FAIL bp_frags got %0d want 32", frag_cnt); end
        n_cmp++; if (comb_bad !== 0 || early_done !== 0) begin n_fail++; $display("FAIL bp_result_path got comb=%0d early=%0d want 0,0", comb_bad, early_done); end
    endtask

    task automatic test_mid_reset();
        bit ok, seen;
        int d0;
        clear_stats(); inside_mode = 1; frag_rdy = 1'b1;
        start_tri(pack3(20, 27, 20), pack3(20, 20, 27), ok);
        repeat (6) @(negedge clk);
        n_cmp++; if (bus.ras_valid !== 1'b1) begin n_fail++; $display("FAIL mr_scanning got %b want 1", bus.ras_valid); end
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.ras_valid, bus.done, bus.tri_ready} !== 3'b000) begin n_fail++; $display("FAIL mr_outputs got valid=%b done=%b ready=%b want 0", bus.ras_valid, bus.done, bus.tri_ready); end
        n_cmp++; if ({bus.ras_vx, bus.ras_pixel_x, bus.ras_pixel_y} !== 55'd0) begin n_fail++; $display("FAIL mr_regs got vx=%h px=%0d py=%0d want 0", bus.ras_vx, bus.ras_pixel_x, bus.ras_pixel_y); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (done_cnt !== d0) begin n_fail++; $display("FAIL mr_no_done got %0d want %0d", done_cnt, d0); end
        clear_stats();
        start_tri(pack3(3, 5, 3), pack3(3, 3, 5), ok);
        wait_done(200, seen);
        n_cmp++; if ({ok, seen} !== 2'b11 || iss_x.size() !== 9 || frag_cnt !== 9) begin n_fail++; $display("FAIL mr_next_tri got ok=%b seen=%b issued=%0d frags=%0d want 1,1,9,9", ok, seen, iss_x.size(), frag_cnt); end
        n_cmp++; if (order_errs(3, 5, 3, 5) !== 0) begin n_fail++; $display("FAIL mr_next_order got %0d bad want 0", order_errs(3, 5, 3, 5)); end
    endtask

    task automatic test_single_pixel();
        bit ok, seen;
        clear_stats(); inside_mode = 1;
        start_tri(pack3(5, 5, 5), pack3(5, 5, 5), ok);
        wait_done(100, seen);
        n_cmp++; if ({ok, seen} !== 2'b11 || iss_x.size() !== 1) begin n_fail++; $display("FAIL sp_issued got ok=%b seen=%b issued=%0d want 1,1,1", ok, seen, iss_x.size()); end
        n_cmp++; if (order_errs(5, 5, 5, 5) !== 0) begin n_fail++; $display("FAIL sp_pixel got %0d bad want 0", order_errs(5, 5, 5, 5)); end
        n_cmp++; if (frag_cnt !== 1) begin n_fail++; $display("FAIL sp_frags got %0d want 1", frag_cnt); end
        n_cmp++; if (last_stat !== (STATS_ON ? 20'd1 : 20'd0)) begin n_fail++; $display("FAIL sp_stat got %0d want %0d", last_stat, STATS_ON ? 1 : 0); end
    endtask

    initial begin
        bus.tri_valid = 1'b0;
        bus.tri_x = '0;
        bus.tri_y = '0;
        exp_vx = '0;
        exp_vy = '0;
        last_stat = '0;
        clear_stats();
        test_reset();
        test_small_tri();
        test_offscreen();
        test_screen_edge();
        test_backpressure();
        test_mid_reset();
        test_single_pixel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
